// File: rtl/decode_pkg.sv
// decode_pkg: shared definitions for the ID stage.
//   - op_e     : opcode encoding carried into EX
//   - state_e  : ID/EX register occupancy
//   - idex_t   : bundle of every field held in the ID/EX register
//   - *_LSB    : bit positions of the instruction fields
// Struct widths follow the default build (64 registers, 32-bit datapath).
package decode_pkg;

    localparam int REG_W  = 6;
    localparam int DATA_W = 32;
    localparam int OP_W   = 6;
    localparam int IMM_W  = 8;

    localparam int OP_LSB  = 26;
    localparam int RD_LSB  = 20;
    localparam int RS0_LSB = 14;
    localparam int RS1_LSB = 8;
    localparam int IMM_LSB = 0;

    typedef enum logic [OP_W-1:0] {
        NOP    = 6'd0,
        ALU_R  = 6'd1,
        ALU_I  = 6'd2,
        LOAD   = 6'd3,
        STORE  = 6'd4,
        BRANCH = 6'd5
    } op_e;

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        op_e               op;
        logic [REG_W-1:0]  wa;
        logic              wen;
        logic              load;
        logic [DATA_W-1:0] opa;
        logic [DATA_W-1:0] opb;
        logic [DATA_W-1:0] imm;
        logic [DATA_W-1:0] pc;
    } idex_t;

endpackage

// File: rtl/decode_stage_instr_decoder.sv
// instr_decoder: purely combinational opcode classifier.
// Ports:
//   op_raw   in  opcode field of the instruction
//   imm8     in  8-bit immediate field
//   op       out normalised opcode (undefined opcodes become NOP)
//   wen      out op writes a register
//   load     out op is a load
//   uses_rs0 out op reads source register 0
//   uses_rs1 out op reads source register 1
//   imm      out immediate sign-extended to BITS
import decode_pkg::*;

module instr_decoder #(
    parameter int BITS = 32
) (
    input  logic [OP_W-1:0]  op_raw,
    input  logic [IMM_W-1:0] imm8,
    output op_e              op,
    output logic             wen,
    output logic             load,
    output logic             uses_rs0,
    output logic             uses_rs1,
    output logic [BITS-1:0]  imm
);

    always_comb begin
        op       = NOP;
        wen      = 1'b0;
        load     = 1'b0;
        uses_rs0 = 1'b0;
        uses_rs1 = 1'b0;
        case (op_raw)
            ALU_R:  begin op = ALU_R;  wen = 1'b1; uses_rs0 = 1'b1; uses_rs1 = 1'b1; end
            ALU_I:  begin op = ALU_I;  wen = 1'b1; uses_rs0 = 1'b1; end
            LOAD:   begin op = LOAD;   wen = 1'b1; load = 1'b1; uses_rs0 = 1'b1; end
            STORE:  begin op = STORE;  uses_rs0 = 1'b1; uses_rs1 = 1'b1; end
            BRANCH: begin op = BRANCH; uses_rs0 = 1'b1; uses_rs1 = 1'b1; end
            default: ;
        endcase
    end

    assign imm = {{(BITS-IMM_W){imm8[IMM_W-1]}}, imm8};

endmodule

// File: rtl/decode_stage.sv
// decode_stage: ID stage of the 5-stage pipeline.
// Accepts one instruction per cycle from IF (valid/ready), drives the
// register-file read addresses combinationally, and captures decoded fields
// and operands into the ID/EX register. Stalls IF on a load-use hazard
// against the op held in ID/EX; flush_i empties ID/EX and refuses IF.
// Ports:
//   clk, rst_n_i                      clock / async active-low reset
//   if_valid_i, if_ready_o            IF handshake
//   if_instr_i, if_pc_i               instruction word and PC from IF
//   flush_i                           kill ID/EX, no accept this cycle
//   rf_ra0_o, rf_ra1_o                register-file read addresses
//   rf_rd0_i, rf_rd1_i                register-file read data (write-bypassed)
//   ex_valid_o, ex_ready_i            EX handshake
//   ex_op_o .. ex_pc_o                ID/EX register contents
//   stall_cnt_o                       stall cycle count (DECODE_STALL_CNT_EN only)
// Optional feature macro: DECODE_STALL_CNT_EN
import decode_pkg::*;

module decode_stage #(
    parameter int NUM_REG = 6,
    parameter int BITS    = 32
) (
    input  logic               clk,
    input  logic               rst_n_i,
    input  logic               if_valid_i,
    output logic               if_ready_o,
    input  logic [BITS-1:0]    if_instr_i,
    input  logic [BITS-1:0]    if_pc_i,
    input  logic               flush_i,
    output logic [NUM_REG-1:0] rf_ra0_o,
    output logic [NUM_REG-1:0] rf_ra1_o,
    input  logic [BITS-1:0]    rf_rd0_i,
    input  logic [BITS-1:0]    rf_rd1_i,
    output logic               ex_valid_o,
    input  logic               ex_ready_i,
    output logic [5:0]         ex_op_o,
    output logic [NUM_REG-1:0] ex_wa_o,
    output logic               ex_wen_o,
    output logic               ex_load_o,
    output logic [BITS-1:0]    ex_opa_o,
    output logic [BITS-1:0]    ex_opb_o,
    output logic [BITS-1:0]    ex_imm_o,
`ifdef DECODE_STALL_CNT_EN
    output logic [31:0]        stall_cnt_o,
`endif
    output logic [BITS-1:0]    ex_pc_o
);

    state_e  state;
    idex_t   idex_p1;
    idex_t   idex_nxt;

    op_e              dec_op;
    logic             dec_wen;
    logic             dec_load;
    logic             uses_rs0;
    logic             uses_rs1;
    logic [BITS-1:0]  dec_imm;
    logic [NUM_REG-1:0] rs0;
    logic [NUM_REG-1:0] rs1;
    logic [NUM_REG-1:0] rd;
    logic             hazard;
    logic             accept;

    assign rs0 = if_instr_i[RS0_LSB +: NUM_REG];
    assign rs1 = if_instr_i[RS1_LSB +: NUM_REG];
    assign rd  = if_instr_i[RD_LSB  +: NUM_REG];

    assign rf_ra0_o = rs0;
    assign rf_ra1_o = rs1;

    instr_decoder #(.BITS(BITS)) u_dec (
        .op_raw   (if_instr_i[OP_LSB +: OP_W]),
        .imm8     (if_instr_i[IMM_LSB +: IMM_W]),
        .op       (dec_op),
        .wen      (dec_wen),
        .load     (dec_load),
        .uses_rs0 (uses_rs0),
        .uses_rs1 (uses_rs1),
        .imm      (dec_imm)
    );

    // Only a load still sitting in ID/EX can hurt: its data is not yet in the
    // register file, so a dependent op must wait until EX has taken it.
    assign hazard = ex_valid_o & idex_p1.load &
                    ((uses_rs0 & (rs0 == idex_p1.wa)) |
                     (uses_rs1 & (rs1 == idex_p1.wa)));

    assign if_ready_o = !flush_i & !hazard & (!ex_valid_o | ex_ready_i);
    assign accept     = if_valid_i & if_ready_o;

    always_comb begin
        idex_nxt      = '0;
        idex_nxt.op   = dec_op;
        idex_nxt.wa   = rd;
        idex_nxt.wen  = dec_wen;
        idex_nxt.load = dec_load;
        idex_nxt.opa  = rf_rd0_i;
        idex_nxt.opb  = rf_rd1_i;
        idex_nxt.imm  = dec_imm;
        idex_nxt.pc   = if_pc_i;
    end

    // ---- ID -> EX register boundary ----
    // accept already implies !flush_i, so flush wins by construction.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state   <= S_EMPTY;
            idex_p1 <= '0;
        end else begin
            case (state)
                S_EMPTY: begin
                    if (accept) begin
                        state   <= S_FULL;
                        idex_p1 <= idex_nxt;
                    end
                end
                S_FULL: begin
                    if (flush_i) begin
                        state <= S_EMPTY;
                    end else if (accept) begin
                        idex_p1 <= idex_nxt;
                    end else if (ex_ready_i) begin
                        state <= S_EMPTY;
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign ex_valid_o = (state == S_FULL);
    assign ex_op_o    = idex_p1.op;
    assign ex_wa_o    = idex_p1.wa;
    assign ex_wen_o   = idex_p1.wen;
    assign ex_load_o  = idex_p1.load;
    assign ex_opa_o   = idex_p1.opa;
    assign ex_opb_o   = idex_p1.opb;
    assign ex_imm_o   = idex_p1.imm;
    assign ex_pc_o    = idex_p1.pc;

`ifdef DECODE_STALL_CNT_EN
    // Saturating count of cycles where IF offered work that decode refused
    // for a reason other than flush.
    always_ff @(posedge clk or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_o <= '0;
        end else if (if_valid_i && !if_ready_o && !flush_i && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

    logic        clk;
    logic        rst_n_i;
    logic        if_valid_i;
    logic        if_ready_o;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        flush_i;
    logic [5:0]  rf_ra0_o;
    logic [5:0]  rf_ra1_o;
    logic [31:0] rf_rd0_i;
    logic [31:0] rf_rd1_i;
    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [5:0]  ex_op_o;
    logic [5:0]  ex_wa_o;
    logic        ex_wen_o;
    logic        ex_load_o;
    logic [31:0] ex_opa_o;
    logic [31:0] ex_opb_o;
    logic [31:0] ex_imm_o;
    logic [31:0] ex_pc_o;
`ifdef DECODE_STALL_CNT_EN
    logic [31:0] stall_cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    logic [31:0] rf [64];
    assign rf_rd0_i = rf[rf_ra0_o];
    assign rf_rd1_i = rf[rf_ra1_o];

    decode_stage dut (
        .clk        (clk),
        .rst_n_i    (rst_n_i),
        .if_valid_i (if_valid_i),
        .if_ready_o (if_ready_o),
        .if_instr_i (if_instr_i),
        .if_pc_i    (if_pc_i),
        .flush_i    (flush_i),
        .rf_ra0_o   (rf_ra0_o),
        .rf_ra1_o   (rf_ra1_o),
        .rf_rd0_i   (rf_rd0_i),
        .rf_rd1_i   (rf_rd1_i),
        .ex_valid_o (ex_valid_o),
        .ex_ready_i (ex_ready_i),
        .ex_op_o    (ex_op_o),
        .ex_wa_o    (ex_wa_o),
        .ex_wen_o   (ex_wen_o),
        .ex_load_o  (ex_load_o),
        .ex_opa_o   (ex_opa_o),
        .ex_opb_o   (ex_opb_o),
        .ex_imm_o   (ex_imm_o),
`ifdef DECODE_STALL_CNT_EN
        .stall_cnt_o(stall_cnt_o),
`endif
        .ex_pc_o    (ex_pc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [5:0]  op;
        logic [5:0]  wa;
        logic        wen;
        logic        load;
        logic [31:0] opa;
        logic [31:0] opb;
        logic [31:0] imm;
    } vec_t;

    vec_t vecs [7];

    function automatic logic [31:0] mk(input logic [5:0] op, input logic [5:0] rd,
                                       input logic [5:0] s0, input logic [5:0] s1,
                                       input logic [7:0] imm8);
        return {op, rd, s0, s1, imm8};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic present(input logic [31:0] instr, input logic [31:0] pc);
        if_instr_i = instr;
        if_pc_i    = pc;
        if_valid_i = 1'b1;
    endtask

    logic [31:0] snap_opa;
    logic [5:0]  snap_wa;
    logic [31:0] snap_pc;

    initial begin
        for (int i = 0; i < 64; i++) rf[i] = 32'h1000 + i;
        rf[1] = 32'd5;
        rf[2] = 32'd7;

        // {instr, pc, op, wa, wen, load, opa, opb, imm}
        vecs[0] = '{mk(6'd1, 6'd3, 6'd1, 6'd2, 8'h00), 32'h100, 6'd1, 6'd3, 1'b1, 1'b0, 32'd5, 32'd7, 32'h0};
        vecs[1] = '{mk(6'd2, 6'd5, 6'd2, 6'd9, 8'hF0), 32'h104, 6'd2, 6'd5, 1'b1, 1'b0, 32'd7, 32'h1009, 32'hFFFF_FFF0};
        vecs[2] = '{mk(6'd3, 6'd4, 6'd1, 6'd0, 8'h7F), 32'h108, 6'd3, 6'd4, 1'b1, 1'b1, 32'd5, 32'h1000, 32'h7F};
        vecs[3] = '{mk(6'd4, 6'd10, 6'd3, 6'd6, 8'h80), 32'h10C, 6'd4, 6'd10, 1'b0, 1'b0, 32'h1003, 32'h1006, 32'hFFFF_FF80};
        vecs[4] = '{mk(6'd5, 6'd0, 6'd1, 6'd2, 8'h01), 32'h110, 6'd5, 6'd0, 1'b0, 1'b0, 32'd5, 32'd7, 32'h1};
        vecs[5] = '{mk(6'd0, 6'd7, 6'd8, 6'd9, 8'h55), 32'h114, 6'd0, 6'd7, 1'b0, 1'b0, 32'h1008, 32'h1009, 32'h55};
        vecs[6] = '{mk(6'd63, 6'd11, 6'd12, 6'd13, 8'hC3), 32'h118, 6'd0, 6'd11, 1'b0, 1'b0, 32'h100C, 32'h100D, 32'hFFFF_FFC3};

        rst_n_i    = 1'b0;
        if_valid_i = 1'b0;
        if_instr_i = '0;
        if_pc_i    = '0;
        flush_i    = 1'b0;
        ex_ready_i = 1'b1;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("reset_opa", ex_opa_o, 32'd0);
        @(negedge clk);
        rst_n_i = 1'b1;
        #1;
        chk("ready_after_reset", {31'd0, if_ready_o}, 32'd1);
        chk("rf_ra0_comb", {26'd0, rf_ra0_o}, 32'd0);

        // Streaming table: one accept per cycle, 1-cycle latency
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            present(vecs[i].instr, vecs[i].pc);
            #1;
            chk($sformatf("v%0d_ready", i), {31'd0, if_ready_o}, 32'd1);
            chk($sformatf("v%0d_ra1", i), {26'd0, rf_ra1_o}, {26'd0, vecs[i].instr[13:8]});
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_valid", i), {31'd0, ex_valid_o}, 32'd1);
            chk($sformatf("v%0d_op", i), {26'd0, ex_op_o}, {26'd0, vecs[i].op});
            chk($sformatf("v%0d_wa", i), {26'd0, ex_wa_o}, {26'd0, vecs[i].wa});
            chk($sformatf("v%0d_wen", i), {31'd0, ex_wen_o}, {31'd0, vecs[i].wen});
            chk($sformatf("v%0d_load", i), {31'd0, ex_load_o}, {31'd0, vecs[i].load});
            chk($sformatf("v%0d_opa", i), ex_opa_o, vecs[i].opa);
            chk($sformatf("v%0d_opb", i), ex_opb_o, vecs[i].opb);
            chk($sformatf("v%0d_imm", i), ex_imm_o, vecs[i].imm);
            chk($sformatf("v%0d_pc", i), ex_pc_o, vecs[i].pc);
        end

        // Mid-run asynchronous reset clears ID/EX immediately
        @(negedge clk);
        if_valid_i = 1'b0;
        rst_n_i    = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, ex_valid_o}, 32'd0);
        chk("midrst_wa", {26'd0, ex_wa_o}, 32'd0);
        chk("midrst_imm", ex_imm_o, 32'd0);
        chk("midrst_pc", ex_pc_o, 32'd0);
        @(negedge clk);
        rst_n_i = 1'b1;
        #1;
        chk("midrst_ready", {31'd0, if_ready_o}, 32'd1);

        // Load-use on rs0: one bubble
        @(negedge clk);
        present(mk(6'd3, 6'd4, 6'd1, 6'd0, 8'h00), 32'h200);
        @(posedge clk);
        @(negedge clk);
        present(mk(6'd1, 6'd6, 6'd4, 6'd2, 8'h00), 32'h204);
        #1;
        chk("lu_ready_low", {31'd0, if_ready_o}, 32'd0);
        chk("lu_load_held", {31'd0, ex_load_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("lu_bubble", {31'd0, ex_valid_o}, 32'd0);
        @(negedge clk);
        #1;
        chk("lu_ready_back", {31'd0, if_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("lu_dep_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("lu_dep_wa", {26'd0, ex_wa_o}, 32'd6);
        chk("lu_dep_opa", ex_opa_o, 32'h1004);

        // Load then ALU_I naming r4 only in rs1: no stall
        @(negedge clk);
        present(mk(6'd3, 6'd4, 6'd1, 6'd0, 8'h00), 32'h208);
        @(posedge clk);
        @(negedge clk);
        present(mk(6'd2, 6'd9, 6'd2, 6'd4, 8'h01), 32'h20C);
        #1;
        chk("alui_no_stall", {31'd0, if_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("alui_op", {26'd0, ex_op_o}, 32'd2);
        chk("alui_pc", ex_pc_o, 32'h20C);

        // Backpressure: 3 cycles with ID/EX full
        @(negedge clk);
        ex_ready_i = 1'b0;
        present(mk(6'd1, 6'd8, 6'd1, 6'd2, 8'h00), 32'h210);
        snap_opa = ex_opa_o;
        snap_wa  = ex_wa_o;
        snap_pc  = ex_pc_o;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_ready", c), {31'd0, if_ready_o}, 32'd0);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_valid", c), {31'd0, ex_valid_o}, 32'd1);
            chk($sformatf("bp%0d_wa", c), {26'd0, ex_wa_o}, {26'd0, snap_wa});
            chk($sformatf("bp%0d_opa", c), ex_opa_o, snap_opa);
            chk($sformatf("bp%0d_pc", c), ex_pc_o, snap_pc);
            @(negedge clk);
        end
        ex_ready_i = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, if_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("bp_accept_wa", {26'd0, ex_wa_o}, 32'd8);
        chk("bp_accept_pc", ex_pc_o, 32'h210);
`ifdef DECODE_STALL_CNT_EN
        chk("stall_cnt", stall_cnt_o, 32'd4);
`endif

        // Flush with ID/EX full and IF valid
        @(negedge clk);
        present(mk(6'd5, 6'd0, 6'd1, 6'd2, 8'h00), 32'h300);
        flush_i = 1'b1;
        #1;
        chk("flush_ready_low", {31'd0, if_ready_o}, 32'd0);
        @(posedge clk);
        #1;
        chk("flush_empty", {31'd0, ex_valid_o}, 32'd0);
        @(negedge clk);
        flush_i = 1'b0;
        #1;
        chk("flush_ready_back", {31'd0, if_ready_o}, 32'd1);
        @(posedge clk);
        #1;
        chk("flush_accept_valid", {31'd0, ex_valid_o}, 32'd1);
        chk("flush_accept_op", {26'd0, ex_op_o}, 32'd5);
        chk("flush_accept_pc", ex_pc_o, 32'h300);
`ifdef DECODE_STALL_CNT_EN
        chk("stall_cnt_flush", stall_cnt_o, 32'd4);
`endif

        // Drain: EX consumes, nothing new offered
        @(negedge clk);
        if_valid_i = 1'b0;
        @(posedge clk);
        #1;
        chk("drain_empty", {31'd0, ex_valid_o}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
